// File: rtl/stall_ctrl_pkg.sv
// Shared stall encodings and multi-cycle sequencer state codes for the core's
// pipeline stall controller.
package stall_ctrl_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/stall_ctrl_mc_seq.sv
// Multi-cycle EX sequencer: IDLE/BUSY/DONE with a countdown loaded at start.
// DONE is held while MEM stalls so the result strobe is not lost.
module mc_seq
  import stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             flush,
  input  logic             mem_stop,
  output logic             busy,
  output logic             done,
  output logic             ex_req
);

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: if (start) begin
        state_nx = ST_BUSY;
        cnt_nx   = (len == '0) ? '0 : len - CNT_W'(1);
      end
      ST_BUSY: begin
        // Countdown keeps running under a MEM stall; only flush/reset stop it.
        if (cnt == '0) state_nx = ST_DONE;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      ST_DONE: if (!mem_stop) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (flush) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign busy   = (state == ST_BUSY);
  assign done   = (state == ST_DONE);
  assign ex_req = ((state == ST_IDLE) && start) || (state == ST_BUSY);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: priority merge of IF/ID/EX/MEM stall requests,
// flush override, multi-cycle EX sequencing and a saturating stall counter.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_from_if,
  input  logic              stallreq_from_id,
  input  logic              stallreq_from_mem,
  input  logic              ex_mc_start,
  input  logic [CNT_W-1:0]  ex_mc_len,
  input  logic              flush,
  input  logic              perf_clr,
  output logic [5:0]        stall,
  output logic              ex_mc_busy,
  output logic              ex_mc_done,
  output logic [PERF_W-1:0] stall_cycles
);

  logic ex_req;

  mc_seq #(.CNT_W(CNT_W)) u_mc_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (ex_mc_start),
    .len      (ex_mc_len),
    .flush    (flush),
    .mem_stop (stall[4] == Stop),
    .busy     (ex_mc_busy),
    .done     (ex_mc_done),
    .ex_req   (ex_req)
  );

  // Requests are gated during reset so nothing leaks out before the FSM is live.
  always_comb begin
    stall = STALL_NONE;
    if (!rst || flush)          stall = {6{NoStop}};
    else if (stallreq_from_mem) stall = STALL_MEM;
    else if (ex_req)            stall = STALL_EX;
    else if (stallreq_from_id)  stall = STALL_ID;
    else if (stallreq_from_if)  stall = STALL_IF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cycles <= '0;
    else if (perf_clr)
      stall_cycles <= '0;
    else if ((stall[0] == Stop) && (stall_cycles != '1))
      stall_cycles <= stall_cycles + PERF_W'(1);
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed checks of stall_ctrl: priority merge, multi-cycle sequencing,
// flush/reset aborts and the saturating stall counter.
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sif, sid, smem, start, flush, pclr;
  logic [5:0]  len;
  logic [5:0]  stall, stall_s;
  logic        busy, done, busy_s, done_s;
  logic [31:0] cyc;
  logic [3:0]  cyc_s;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  stall_ctrl dut (
    .clk(clk), .rst(rst), .stallreq_from_if(sif), .stallreq_from_id(sid),
    .stallreq_from_mem(smem), .ex_mc_start(start), .ex_mc_len(len),
    .flush(flush), .perf_clr(pclr), .stall(stall), .ex_mc_busy(busy),
    .ex_mc_done(done), .stall_cycles(cyc)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  stall_ctrl #(.CNT_W(6), .PERF_W(4)) dut_s (
    .clk(clk), .rst(rst), .stallreq_from_if(sif), .stallreq_from_id(sid),
    .stallreq_from_mem(smem), .ex_mc_start(start), .ex_mc_len(len),
    .flush(flush), .perf_clr(pclr), .stall(stall_s), .ex_mc_busy(busy_s),
    .ex_mc_done(done_s), .stall_cycles(cyc_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk); #1;
  endtask

  task automatic sm();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; sif = 0; sid = 0; smem = 1; start = 0; len = 0; flush = 0; pclr = 0;
    #12;
    chk("rst_stall_gated", {26'd0, stall}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_cnt", cyc, 0);
    smem = 0;
    nx(); rst = 1'b1;
    sm(); chk("idle_stall", {26'd0, stall}, 32'h00);
    chk("idle_cnt", cyc, 0);

    // one-cycle ID request
    nx(); sid = 1;
    sm(); chk("id_stall", {26'd0, stall}, 32'h07);
    nx(); sid = 0;
    sm(); chk("id_drop", {26'd0, stall}, 32'h00);
    chk("id_cnt", cyc, 1);

    // ID beats IF
    nx(); sid = 1; sif = 1;
    sm(); chk("id_over_if", {26'd0, stall}, 32'h07);
    nx(); sid = 0; sif = 0;   // cnt = 2

    // len=4: 5 stalled cycles, then DONE, then IDLE
    nx(); start = 1; len = 6'd4;
    sm(); chk("mc4_c0_stall", {26'd0, stall}, 32'h0F);
    chk("mc4_c0_busy", {31'd0, busy}, 0);
    for (int i = 1; i <= 4; i++) begin
      nx(); start = 0;
      sm(); chk($sformatf("mc4_c%0d_stall", i), {26'd0, stall}, 32'h0F);
      chk($sformatf("mc4_c%0d_busy", i), {31'd0, busy}, 1);
    end
    nx();
    sm(); chk("mc4_done", {31'd0, done}, 1);
    chk("mc4_done_stall", {26'd0, stall}, 32'h00);
    nx();
    sm(); chk("mc4_idle_done", {31'd0, done}, 0);
    chk("mc4_cnt", cyc, 7);

    // len=0 behaves as 1: 2 stalled cycles
    nx(); start = 1; len = 6'd0;
    sm(); chk("mc0_c0", {26'd0, stall}, 32'h0F);
    nx(); start = 0;
    sm(); chk("mc0_c1", {26'd0, stall}, 32'h0F);
    nx();
    sm(); chk("mc0_done", {31'd0, done}, 1);
    chk("mc0_done_stall", {26'd0, stall}, 32'h00);
    nx();
    sm(); chk("mc0_idle", {31'd0, done}, 0);
    chk("mc0_cnt", cyc, 9);

    // ID + EX start + MEM together, MEM held through DONE
    nx(); sid = 1; smem = 1; start = 1; len = 6'd2;
    sm(); chk("all_c0", {26'd0, stall}, 32'h1F);
    nx(); sid = 0; start = 0;
    sm(); chk("all_c1", {26'd0, stall}, 32'h1F);
    chk("all_c1_busy", {31'd0, busy}, 1);
    nx();
    sm(); chk("all_c2", {31'd0, busy}, 1);
    nx();
    sm(); chk("all_done_a", {31'd0, done}, 1);
    chk("all_done_stall", {26'd0, stall}, 32'h1F);
    nx();
    sm(); chk("all_done_held", {31'd0, done}, 1);
    nx(); smem = 0;
    sm(); chk("all_done_last", {31'd0, done}, 1);
    chk("all_done_nostall", {26'd0, stall}, 32'h00);
    nx();
    sm(); chk("all_idle", {31'd0, done}, 0);
    chk("all_cnt", cyc, 14);

    // flush in BUSY (len=10, cycle 3)
    nx(); start = 1; len = 6'd10;
    nx(); start = 0;
    nx();
    nx(); flush = 1;
    sm(); chk("fl_stall", {26'd0, stall}, 32'h00);
    chk("fl_busy_still", {31'd0, busy}, 1);
    nx(); flush = 0;
    sm(); chk("fl_idle_busy", {31'd0, busy}, 0);
    chk("fl_idle_done", {31'd0, done}, 0);
    nx();
    sm(); chk("fl_no_done", {31'd0, done}, 0);
    chk("fl_cnt", cyc, 17);

    // flush and start together in IDLE: flush wins
    nx(); start = 1; flush = 1; len = 6'd3;
    sm(); chk("flst_stall", {26'd0, stall}, 32'h00);
    nx(); start = 0; flush = 0;
    sm(); chk("flst_busy", {31'd0, busy}, 0);
    chk("flst_stall2", {26'd0, stall}, 32'h00);

    // start held: ignored in BUSY/DONE, accepted again in next IDLE
    nx(); start = 1; len = 6'd1;
    nx();
    sm(); chk("re_busy", {31'd0, busy}, 1);
    nx();
    sm(); chk("re_done", {31'd0, done}, 1);
    chk("re_done_stall", {26'd0, stall}, 32'h00);
    nx();
    sm(); chk("re_idle_start", {26'd0, stall}, 32'h0F);
    chk("re_idle_busy", {31'd0, busy}, 0);
    nx(); start = 0;
    sm(); chk("re_busy2", {31'd0, busy}, 1);
    chk("re_cnt", cyc, 20);

    // async reset mid-BUSY
    #2 rst = 1'b0;
    #1 chk("ar_busy", {31'd0, busy}, 0);
    chk("ar_stall", {26'd0, stall}, 32'h00);
    chk("ar_cnt", cyc, 0);
    nx(); rst = 1'b1;
    sm(); chk("ar_no_done", {31'd0, done}, 0);
    nx();
    sm(); chk("ar_no_done2", {31'd0, done}, 0);

    // 20 IF-stalled cycles: wide counter 20, narrow counter saturates
    nx(); sif = 1;
    sm(); chk("if_stall", {26'd0, stall}, 32'h03);
    for (int i = 1; i < 20; i++) nx();
    nx(); sif = 0;
    sm(); chk("sat_wide", cyc, 20);
    chk("sat_narrow", {28'd0, cyc_s}, 32'hF);
    nx();
    sm(); chk("sat_narrow_hold", {28'd0, cyc_s}, 32'hF);

    // clear beats increment
    nx(); sif = 1; pclr = 1;
    nx(); sif = 0; pclr = 0;
    sm(); chk("clr_wide", cyc, 0);
    chk("clr_narrow", {28'd0, cyc_s}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
